// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the 5x5 systolic tile sequencer.
package sa_pkg;
  localparam int unsigned SA_ARRAY   = 5;
  localparam int unsigned SA_K_DEPTH = 5;
  localparam int unsigned SA_PHASE_W = SA_ARRAY * SA_ARRAY;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_FEED  = 4'd2,
    S_FLUSH = 4'd3,
    S_READ  = 4'd4,
    S_DRAIN = 4'd5,
    S_NEXT  = 4'd6,
    S_DONE  = 4'd7,
    S_ERR   = 4'd8
  } sa_state_e;
endpackage

// File: rtl/sa_skew_gen.sv
// Diagonal FIFO read-enable pattern: lane i reads for K_DEPTH cycles starting at f = i.
module sa_skew_gen
  import sa_pkg::*;
#(
  parameter int unsigned ARRAY   = SA_ARRAY,
  parameter int unsigned K_DEPTH = SA_K_DEPTH
) (
  input  logic [CNT_W-1:0] f,
  input  logic             en,
  output logic [ARRAY-1:0] rd_en
);
  logic [31:0] fi;

  assign fi = 32'(f);

  always_comb begin
    rd_en = '0;
    for (int unsigned i = 0; i < ARRAY; i++) begin
      rd_en[i] = en && (fi >= i) && (fi < i + K_DEPTH);
    end
  end
endmodule

// File: rtl/sa_tile_scheduler.sv
// Tile sequencer for the systolic array: load, skewed feed, flush, read, drain per tile.
module sa_tile_scheduler
  import sa_pkg::*;
#(
  parameter int unsigned ARRAY       = SA_ARRAY,
  parameter int unsigned K_DEPTH     = SA_K_DEPTH,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TILE_STRIDE = 25,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_a,
  input  logic [ADDR_W-1:0]      base_b,
  input  logic [3:0]             num_tiles,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   init_a,
  output logic                   init_b,
  output logic [ADDR_W-1:0]      base_a_out,
  output logic [ADDR_W-1:0]      base_b_out,
  input  logic                   com_a,
  input  logic                   com_b,
  output logic [ARRAY-1:0]       rd_en_a,
  output logic [ARRAY-1:0]       rd_en_b,
  output logic [ARRAY*ARRAY-1:0] pe_clr,
  output logic [ARRAY*ARRAY-1:0] pe_read,
  output logic [ARRAY*ARRAY-1:0] pe_write,
  output logic                   out_valid,
  output logic [2:0]             out_row,
  output logic [3:0]             tile_idx
);
  localparam int unsigned PW    = ARRAY * ARRAY;
  localparam int unsigned TMO_W = 8;
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(K_DEPTH + ARRAY - 2);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(2 * ARRAY - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ARRAY - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

  sa_state_e         state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [TMO_W-1:0]  tmo, tmo_d;
  logic              flag_a, flag_a_d, flag_b, flag_b_d;
  logic [3:0]        tile, tile_d, nt, nt_d;
  logic [ADDR_W-1:0] ba, ba_d, bb, bb_d;
  logic              err, err_d;

  logic              busy_d, done_d, init_d, out_valid_d;
  logic [2:0]        out_row_d;
  logic [3:0]        tile_idx_d;
  logic [ADDR_W-1:0] base_a_d, base_b_d;
  logic [PW-1:0]     pe_clr_d, pe_read_d, pe_write_d;
  logic [CNT_W-1:0]  f_d;
  logic [ARRAY-1:0]  skew_a_d, skew_b_d;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    tmo_d    = '0;
    flag_a_d = 1'b0;
    flag_b_d = 1'b0;
    tile_d   = tile;
    nt_d     = nt;
    ba_d     = ba;
    bb_d     = bb;
    err_d    = err;
    case (state)
      S_IDLE: begin
        if (start && num_tiles != '0) begin
          state_d = S_LOAD;
          ba_d    = base_a;
          bb_d    = base_b;
          nt_d    = num_tiles;
          tile_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        // completion wins over a timeout landing in the same cycle
        flag_a_d = flag_a | com_a;
        flag_b_d = flag_b | com_b;
        if (flag_a_d && flag_b_d) begin
          state_d  = S_FEED;
          cnt_d    = FEED_LAST;
          flag_a_d = 1'b0;
          flag_b_d = 1'b0;
        end else if (tmo == TMO_LAST) begin
          state_d  = S_ERR;
          err_d    = 1'b1;
          flag_a_d = 1'b0;
          flag_b_d = 1'b0;
        end else begin
          tmo_d = tmo + 1'b1;
        end
      end
      S_FEED: begin
        if (cnt == '0) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LAST;
        end else cnt_d = cnt - 1'b1;
      end
      S_FLUSH: begin
        if (cnt == '0) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else cnt_d = cnt - 1'b1;
      end
      S_READ: begin
        state_d = S_DRAIN;
        cnt_d   = DRAIN_LAST;
      end
      S_DRAIN: begin
        if (cnt == '0) state_d = S_NEXT;
        else cnt_d = cnt - 1'b1;
      end
      S_NEXT: begin
        if ({1'b0, tile} + 5'd1 < {1'b0, nt}) begin
          tile_d  = tile + 4'd1;
          state_d = S_LOAD;
        end else state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  assign f_d = FEED_LAST - cnt_d;

  sa_skew_gen #(.ARRAY(ARRAY), .K_DEPTH(K_DEPTH)) u_skew_a (
    .f(f_d), .en(state_d == S_FEED), .rd_en(skew_a_d)
  );
  sa_skew_gen #(.ARRAY(ARRAY), .K_DEPTH(K_DEPTH)) u_skew_b (
    .f(f_d), .en(state_d == S_FEED), .rd_en(skew_b_d)
  );

  always_comb begin
    busy_d      = state_d != S_IDLE;
    done_d      = (state_d == S_DONE) || (state == S_IDLE && start && num_tiles == '0);
    init_d      = (state_d == S_LOAD) && (state != S_LOAD);
    out_valid_d = state_d == S_DRAIN;
    out_row_d   = '0;
    if (state_d == S_DRAIN) out_row_d = 3'(cnt_d);
    pe_clr_d = '0;
    if (state_d inside {S_IDLE, S_LOAD, S_NEXT, S_DONE, S_ERR}) pe_clr_d = '1;
    pe_read_d = '0;
    if (state_d == S_READ) pe_read_d = '1;
    pe_write_d = '0;
    if (state_d == S_DRAIN) pe_write_d = '1;
    tile_idx_d = '0;
    base_a_d   = '0;
    base_b_d   = '0;
    if (state_d != S_IDLE) begin
      tile_idx_d = tile_d;
      base_a_d   = ba_d + ADDR_W'(32'(tile_d) * TILE_STRIDE);
      base_b_d   = bb_d + ADDR_W'(32'(tile_d) * TILE_STRIDE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      tmo    <= '0;
      flag_a <= 1'b0;
      flag_b <= 1'b0;
      tile   <= '0;
      nt     <= '0;
      ba     <= '0;
      bb     <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      tmo    <= tmo_d;
      flag_a <= flag_a_d;
      flag_b <= flag_b_d;
      tile   <= tile_d;
      nt     <= nt_d;
      ba     <= ba_d;
      bb     <= bb_d;
      err    <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      init_a     <= 1'b0;
      init_b     <= 1'b0;
      base_a_out <= '0;
      base_b_out <= '0;
      rd_en_a    <= '0;
      rd_en_b    <= '0;
      pe_clr     <= '1;
      pe_read    <= '0;
      pe_write   <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      tile_idx   <= '0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      error      <= err_d;
      init_a     <= init_d;
      init_b     <= init_d;
      base_a_out <= base_a_d;
      base_b_out <= base_b_d;
      rd_en_a    <= skew_a_d;
      rd_en_b    <= skew_b_d;
      pe_clr     <= pe_clr_d;
      pe_read    <= pe_read_d;
      pe_write   <= pe_write_d;
      out_valid  <= out_valid_d;
      out_row    <= out_row_d;
      tile_idx   <= tile_idx_d;
    end
  end
endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed bench for sa_tile_scheduler; inputs driven and outputs sampled on the falling edge.
module tb_sa_tile_scheduler;
  localparam logic [31:0] ONES = 32'h01FF_FFFF;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, com_a = 1'b0, com_b = 1'b0;
  logic [7:0]  base_a = '0, base_b = '0;
  logic [3:0]  num_tiles = '0;
  logic        busy, done, error, init_a, init_b, out_valid;
  logic [7:0]  base_a_out, base_b_out;
  logic [4:0]  rd_en_a, rd_en_b;
  logic [24:0] pe_clr, pe_read, pe_write;
  logic [2:0]  out_row;
  logic [3:0]  tile_idx;

  int total = 0;
  int bad   = 0;
  logic [4:0] feed_exp [9];
  logic [7:0] exp3_a [3];

  always #5 clk = ~clk;

  sa_tile_scheduler #(
    .ARRAY(5), .K_DEPTH(5), .ADDR_W(8), .TILE_STRIDE(25), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_a(base_a), .base_b(base_b),
    .num_tiles(num_tiles), .busy(busy), .done(done), .error(error),
    .init_a(init_a), .init_b(init_b), .base_a_out(base_a_out), .base_b_out(base_b_out),
    .com_a(com_a), .com_b(com_b), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
    .pe_clr(pe_clr), .pe_read(pe_read), .pe_write(pe_write),
    .out_valid(out_valid), .out_row(out_row), .tile_idx(tile_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge while IDLE; returns on the falling edge of LOAD cycle 1.
  task automatic kick(input logic [7:0] ba, input logic [7:0] bb, input logic [3:0] nt);
    base_a    = ba;
    base_b    = bb;
    num_tiles = nt;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From LOAD cycle 1, pulse com_a in cycle ca and com_b in cycle cb; returns at first FEED cycle.
  task automatic load_phase(input int ca, input int cb);
    int last;
    last = (ca > cb) ? ca : cb;
    for (int c = 1; c <= last; c++) begin
      com_a = (c == ca);
      com_b = (c == cb);
      if (c == 2) check("load_init_off", 32'(init_a), 0);
      @(negedge clk);
    end
    com_a = 1'b0;
    com_b = 1'b0;
  endtask

  // From the first FEED cycle through FLUSH, READ, DRAIN; returns at the NEXT cycle.
  task automatic tile_tail();
    for (int f = 0; f < 9; f++) begin
      check("feed_rd_a", 32'(rd_en_a), 32'(feed_exp[f]));
      check("feed_rd_b", 32'(rd_en_b), 32'(feed_exp[f]));
      if (f == 0) check("feed_clr", 32'(pe_clr), 0);
      @(negedge clk);
    end
    for (int c = 0; c < 9; c++) begin
      check("flush_rd", 32'({rd_en_a, rd_en_b}), 0);
      check("flush_ov", 32'(out_valid), 0);
      @(negedge clk);
    end
    check("read_pe", 32'(pe_read), ONES);
    @(negedge clk);
    for (int d = 0; d < 5; d++) begin
      check("drain_ov", 32'(out_valid), 1);
      check("drain_row", 32'(out_row), 32'(4 - d));
      check("drain_wr", 32'(pe_write), ONES);
      @(negedge clk);
    end
    check("next_clr", 32'(pe_clr), ONES);
    check("next_ov", 32'(out_valid), 0);
  endtask

  initial begin
    feed_exp = '{5'h01, 5'h03, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C, 5'h18, 5'h10};
    exp3_a   = '{8'hF0, 8'h09, 8'h22};
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_clr", 32'(pe_clr), ONES);
    check("rst_err", 32'(error), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tile", 32'(tile_idx), 0);
    check("rst_base_a", 32'(base_a_out), 0);
    rst = 1'b0;
    @(negedge clk);

    // single tile, FEED on cycle 49
    kick(8'h10, 8'h20, 4'd1);
    check("t1_init_a", 32'(init_a), 1);
    check("t1_init_b", 32'(init_b), 1);
    check("t1_busy", 32'(busy), 1);
    check("t1_base_a", 32'(base_a_out), 32'h10);
    check("t1_base_b", 32'(base_b_out), 32'h20);
    load_phase(46, 48);
    tile_tail();
    check("t1_next_done", 32'(done), 0);
    @(negedge clk);
    check("t1_done", 32'(done), 1);
    check("t1_done_busy", 32'(busy), 1);
    @(negedge clk);
    check("t1_done_off", 32'(done), 0);
    check("t1_idle", 32'(busy), 0);

    // three tiles with base_a wrap
    kick(8'hF0, 8'h00, 4'd3);
    for (int t = 0; t < 3; t++) begin
      check("t3_init", 32'(init_a), 1);
      check("t3_base_a", 32'(base_a_out), 32'(exp3_a[t]));
      check("t3_base_b", 32'(base_b_out), 32'(t * 25));
      check("t3_tile", 32'(tile_idx), 32'(t));
      load_phase(2, 3);
      tile_tail();
      check("t3_no_done", 32'(done), 0);
      @(negedge clk);
    end
    check("t3_done", 32'(done), 1);
    @(negedge clk);

    // simultaneous completion
    kick(8'h00, 8'h00, 4'd1);
    load_phase(5, 5);
    tile_tail();
    @(negedge clk);
    check("sim_done", 32'(done), 1);
    @(negedge clk);

    // completion in the timeout cycle counts as success
    kick(8'h00, 8'h00, 4'd1);
    load_phase(1, 255);
    check("edge_err", 32'(error), 0);
    tile_tail();
    @(negedge clk);
    @(negedge clk);

    // load timeout
    kick(8'h00, 8'h00, 4'd1);
    for (int c = 1; c <= 255; c++) begin
      com_a = (c == 3);
      if (c == 255) begin
        check("tmo_busy", 32'(busy), 1);
        check("tmo_err_pre", 32'(error), 0);
      end
      @(negedge clk);
    end
    com_a = 1'b0;
    check("tmo_err", 32'(error), 1);
    check("tmo_err_busy", 32'(busy), 1);
    check("tmo_clr", 32'(pe_clr), ONES);
    check("tmo_rd", 32'(rd_en_a), 0);
    @(negedge clk);
    check("tmo_idle", 32'(busy), 0);
    check("tmo_sticky", 32'(error), 1);
    @(negedge clk);
    check("tmo_sticky2", 32'(error), 1);
    kick(8'h00, 8'h00, 4'd1);
    check("tmo_cleared", 32'(error), 0);
    load_phase(1, 1);
    tile_tail();
    @(negedge clk);
    @(negedge clk);

    // zero tiles
    kick(8'h00, 8'h00, 4'd0);
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    check("zero_init", 32'(init_a), 0);
    @(negedge clk);
    check("zero_done_off", 32'(done), 0);

    // start while busy is ignored
    kick(8'h40, 8'h00, 4'd1);
    load_phase(2, 2);
    start  = 1'b1;
    base_a = 8'h77;
    tile_tail();
    start = 1'b0;
    check("busy_tile", 32'(tile_idx), 0);
    @(negedge clk);
    check("busy_done", 32'(done), 1);
    check("busy_base", 32'(base_a_out), 32'h40);
    @(negedge clk);
    check("busy_idle", 32'(busy), 0);

    // reset during DRAIN of the second tile
    kick(8'h10, 8'h20, 4'd2);
    load_phase(1, 1);
    tile_tail();
    @(negedge clk);
    check("rm_tile1", 32'(tile_idx), 1);
    check("rm_base_a", 32'(base_a_out), 32'h29);
    load_phase(1, 1);
    repeat (20) @(negedge clk);
    check("rm_ov_pre", 32'(out_valid), 1);
    check("rm_row_pre", 32'(out_row), 3);
    rst = 1'b1;
    #1;
    check("rm_ov", 32'(out_valid), 0);
    check("rm_clr", 32'(pe_clr), ONES);
    check("rm_busy", 32'(busy), 0);
    check("rm_tile", 32'(tile_idx), 0);
    check("rm_wr", 32'(pe_write), 0);
    check("rm_base", 32'(base_a_out), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rm_stay_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end
endmodule
